// File: rtl/pooling_if.sv
// Pixel-stream bus between a frame source and the 2x2 pooling engine.
//
// Handshake: a pixel transfers on a rising clk edge where in_valid and
// in_ready are both high; in_pixel must be stable while in_valid is high,
// and the source may drop in_valid for any number of cycles. out_valid is
// a one-cycle pulse with no backpressure, so the sink must take every
// result the cycle it is presented. start is a request sampled only while
// the engine is idle; mode is captured with it.
interface pooling_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_pixel;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_pixel;
    logic              busy;
    logic              finish;

    modport master (
        output start, mode, in_valid, in_pixel,
        input  in_ready, out_valid, out_pixel, busy, finish
    );

    modport slave (
        input  start, mode, in_valid, in_pixel,
        output in_ready, out_valid, out_pixel, busy, finish
    );
endinterface

// File: rtl/pooling_engine.sv
// 2x2 stride-2 pooling over a row-major pixel stream (average or max).
// Even-row pairs are folded into a half-width line buffer; the matching
// odd-row pair completes the window and produces one registered result.
module pooling_engine #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    pooling_if.slave   bus,
    output logic [1:0] dbg_state_o
);
    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int SW     = DATA_W + 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              mode_q, mode_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_pixel_q;

    logic              in_ready;
    logic              busy;
    logic              finish;
    logic              start_acc;
    logic              accept;
    logic              last_pix;
    logic              complete;
    logic              lb_write;

    // Partial sums live at DATA_W+2 bits so four full-scale pixels never overflow.
    logic signed [SW-1:0] lbuf_q [HALF_W];
    logic [LW-1:0]        lb_idx;
    logic signed [SW-1:0] lb_rd;
    logic signed [SW-1:0] cur_ext;
    logic signed [SW-1:0] hold_ext;
    logic signed [SW-1:0] pair_sum;
    logic signed [SW-1:0] pair_max;
    logic signed [SW-1:0] partial;
    logic signed [SW-1:0] quad_sum;
    logic [DATA_W-1:0]    quad_avg;
    logic [DATA_W-1:0]    quad_max;
    logic [DATA_W-1:0]    result;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign accept    = bus.in_valid && in_ready;
    assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign complete  = accept && col_q[0] && row_q[0];
    assign lb_write  = accept && col_q[0] && !row_q[0];
    assign lb_idx    = LW'(col_q >> 1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start only counts in IDLE; LAST lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (accept && last_pix) state_d = ST_LAST;
            ST_LAST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the final result pulse lands in LAST, so finish rides on it.
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b0;
        finish      = 1'b0;
        dbg_state_o = state_q;
        case (state_q)
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_LAST: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter, held-pixel and mode next-state; a start outside IDLE never reaches here.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        mode_d = mode_q;
        if (start_acc) begin
            col_d  = '0;
            row_d  = '0;
            mode_d = bus.mode;
        end else if (accept) begin
            if (!col_q[0]) hold_d = bus.in_pixel;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Counter, held-pixel and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            mode_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            mode_q <= mode_d;
        end
    end

    // Window datapath: pair from held + current pixel, then fold with the buffered pair.
    always_comb begin
        cur_ext  = {{2{bus.in_pixel[DATA_W-1]}}, bus.in_pixel};
        hold_ext = {{2{hold_q[DATA_W-1]}}, hold_q};
        lb_rd    = lbuf_q[lb_idx];
        pair_sum = hold_ext + cur_ext;
        pair_max = (cur_ext > hold_ext) ? cur_ext : hold_ext;
        partial  = mode_q ? pair_max : pair_sum;
        quad_sum = pair_sum + lb_rd;
        // Dropping the two LSBs of the signed sum is the floor divide by four.
        quad_avg = quad_sum[SW-1:2];
        quad_max = (lb_rd > pair_max) ? lb_rd[DATA_W-1:0] : pair_max[DATA_W-1:0];
        result   = mode_q ? quad_max : quad_avg;
    end

    // Line buffer of even-row pair partials; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (lb_write) lbuf_q[lb_idx] <= partial;
    end

    // Result register: one-cycle valid pulse, pixel held between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            out_valid_q <= complete;
            if (complete) out_pixel_q <= result;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.finish    = finish;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
endmodule

// File: tb/tb_pooling_engine.sv
// Directed bench for pooling_engine on a 4x4 frame: hand-computed window
// results are queued by the driver and matched by a negedge monitor.
module tb_pooling_engine;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    pooling_if #(.DATA_W(DW)) bus ();
    logic [1:0] dbg_state;

    pooling_engine #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    bit            exp_fin_q[$];

    logic [DW-1:0] px [W*H];
    logic [DW-1:0] ex [(W/2)*(H/2)];

    logic [DW-1:0] mon_e;
    int            mon_c;
    bit            mon_f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Every out_valid must match the oldest queued window, on time.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("stray_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                mon_f = exp_fin_q.pop_front();
                check("out_pixel", 32'(bus.out_pixel), 32'(mon_e));
                check("out_cycle", 32'(cyc), 32'(mon_c));
                check("finish", 32'(bus.finish), 32'(mon_f));
            end
        end else if (bus.finish) begin
            check("stray_finish", 32'(bus.finish), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic m);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("state_run", 32'(dbg_state), 32'd1);
    endtask

    task automatic send_pix(input int idx, input int gap, input bit poke_start);
        int r;
        int c;
        r = idx / W;
        c = idx % W;
        check("in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_pixel = px[idx];
        if (poke_start) begin
            bus.start = 1'b1;
            bus.mode  = 1'b1;
        end
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            exp_q.push_back(ex[(r / 2) * (W / 2) + c / 2]);
            exp_cyc_q.push_back(cyc + 1);
            exp_fin_q.push_back(idx == W * H - 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.in_pixel = 16'($urandom_range(0, 65535));
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic run_frame(input int gap, input int poke_idx);
        for (int i = 0; i < W * H; i++) send_pix(i, gap, i == poke_idx);
        drain();
    endtask

    task automatic load_frame_a();
        px = '{16'sd4, 16'sd8, 16'sd1, 16'sd1,
               16'sd12, 16'sd16, 16'sd1, 16'sd1,
               16'sd0, 16'sd0, -16'sd1, -16'sd2,
               16'sd0, 16'sd0, -16'sd3, -16'sd4};
        ex = '{16'sd10, 16'sd1, 16'sd0, -16'sd3};
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        check("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Average frame with mixed-sign windows.
        load_frame_a();
        do_start(1'b0);
        run_frame(0, -1);

        // Max frame: negatives, full-scale positive, full-scale negative, mixed.
        px = '{-16'sd5, -16'sd1, 16'sd32767, 16'sd0,
               -16'sd7, -16'sd3, 16'sd0, 16'sd0,
               16'h8000, 16'h8000, 16'sd3, 16'sd9,
               16'h8000, 16'h8000, 16'sd2, -16'sd4};
        ex = '{-16'sd1, 16'sd32767, 16'h8000, 16'sd9};
        do_start(1'b1);
        run_frame(0, -1);

        // Average at full scale both ways, plus floor rounding of small values.
        px = '{16'sd32767, 16'sd32767, 16'h8000, 16'h8000,
               16'sd32767, 16'sd32767, 16'h8000, 16'h8000,
               16'sd1, 16'sd2, -16'sd1, 16'sd0,
               16'sd3, 16'sd4, 16'sd0, 16'sd0};
        ex = '{16'sd32767, 16'h8000, 16'sd2, -16'sd1};
        do_start(1'b0);
        run_frame(0, -1);

        // Same average frame with three idle cycles between pixels.
        load_frame_a();
        do_start(1'b0);
        run_frame(3, -1);

        // Reset after the ninth pixel, then a clean frame.
        load_frame_a();
        do_start(1'b0);
        for (int i = 0; i < 9; i++) send_pix(i, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_out_pixel", 32'(bus.out_pixel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        do_start(1'b0);
        run_frame(0, -1);

        // Start with mode=1 during RUN must not switch the frame to max.
        load_frame_a();
        do_start(1'b0);
        run_frame(0, 2);

        repeat (3) @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end
endmodule
